// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and
// the operation-select encodings.
package alu_pkg;

  localparam int WIDTH = 16;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_NOR  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_PASS = 3'b110;
  localparam logic [2:0] ALU_ZERO = 3'b111;

endpackage

// File: rtl/alu_1b.sv
// One bit slice of the ripple ALU. set/ovf only
// carry meaning on the most significant slice.
module alu_1b
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b_in,
  input  logic       bnegate,
  input  logic       cin,
  input  logic       less,
  input  logic [2:0] op,
  output logic       result,
  output logic       cout,
  output logic       set,
  output logic       ovf
);

  logic bb;
  logic sum;

  assign bb   = bnegate ? ~b_in : b_in;
  assign sum  = a ^ bb ^ cin;
  assign cout = (a & bb) | (a & cin) | (bb & cin);
  assign ovf  = (a == bb) && (sum != a);
  // sign of the true difference, corrected for overflow
  assign set  = sum ^ ovf;

  always_comb begin
    result = 1'b0;
    unique case (1'b1)
      (op == ALU_AND):  result = a & bb;
      (op == ALU_NOR):  result = ~(a | bb);
      (op == ALU_OR):   result = a | bb;
      (op == ALU_XOR):  result = a ^ bb;
      (op == ALU_ADD):  result = sum;
      (op == ALU_SLT):  result = less;
      (op == ALU_PASS): result = a;
      (op == ALU_ZERO): result = 1'b0;
      default:          result = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_16b.sv
// Registered 16-bit ALU: ripple slice chain,
// zero detect and a one-cycle output register.
module alu_16b
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BNegate,
  input  logic [2:0]       ALUCtrl,
  output logic             Zero,
  output logic             Overflow,
  output logic [WIDTH-1:0] REZ,
  output logic             CarryOut
);

  logic             is_slt;
  logic             is_add;
  logic             binv;
  logic [WIDTH-1:0] rez_c;
  logic [WIDTH-1:0] set_v;
  logic [WIDTH-1:0] ovf_v;
  logic             cout_msb;
  logic             ovf_n;
  logic             co_n;
  logic             zero_n;
  logic             unused_lsb;

  assign is_slt = (ALUCtrl == ALU_SLT);
  assign is_add = (ALUCtrl == ALU_ADD);
  // SLT always subtracts, whatever BNegate says
  assign binv   = BNegate | is_slt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic ci;
    logic co;
    logic lt;
    if (i == 0) begin : g_lsb
      assign ci = binv;
      assign lt = set_v[WIDTH-1];
    end else begin : g_up
      assign ci = g_bit[i-1].co;
      assign lt = 1'b0;
    end
    alu_1b u_bit (
      .a       (A[i]),
      .b_in    (B[i]),
      .bnegate (binv),
      .cin     (ci),
      .less    (lt),
      .op      (ALUCtrl),
      .result  (rez_c[i]),
      .cout    (co),
      .set     (set_v[i]),
      .ovf     (ovf_v[i])
    );
  end

  assign cout_msb = g_bit[WIDTH-1].co;
  assign ovf_n    = is_add & ovf_v[WIDTH-1];
  assign co_n     = is_add & cout_msb;
  assign zero_n   = (rez_c == '0);

  assign unused_lsb = ^{set_v[WIDTH-2:0], ovf_v[WIDTH-2:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      REZ      <= '0;
      Zero     <= 1'b1;
      Overflow <= 1'b0;
      CarryOut <= 1'b0;
    end else begin
      REZ      <= rez_c;
      Zero     <= zero_n;
      Overflow <= ovf_n;
      CarryOut <= co_n;
    end
  end

endmodule

// File: tb/tb_alu_16b.sv
// Self-checking bench for alu_16b: directed
// cases plus randomized ops against a model.
module tb_alu_16b;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] A;
  logic [15:0] B;
  logic        BNegate;
  logic [2:0]  ALUCtrl;
  logic        Zero;
  logic        Overflow;
  logic [15:0] REZ;
  logic        CarryOut;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_16b dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .BNegate  (BNegate),
    .ALUCtrl  (ALUCtrl),
    .Zero     (Zero),
    .Overflow (Overflow),
    .REZ      (REZ),
    .CarryOut (CarryOut)
  );

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic model(input  logic [15:0] a,
                       input  logic [15:0] b,
                       input  logic        bn,
                       input  logic [2:0]  c,
                       output logic [15:0] r,
                       output logic        z,
                       output logic        ov,
                       output logic        co);
    int sa;
    int sb;
    int s;
    logic [15:0] bo;
    logic [16:0] wide;
    bo   = bn ? ~b : b;
    wide = {1'b0, a} + {1'b0, bo} + {16'd0, bn};
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    ov   = 1'b0;
    co   = 1'b0;
    case (c)
      3'b000: r = a & bo;
      3'b001: r = ~(a | bo);
      3'b010: r = a | bo;
      3'b011: r = a ^ bo;
      3'b100: begin
        r  = wide[15:0];
        co = wide[16];
        s  = bn ? sa - sb : sa + sb;
        ov = (s > 32767) || (s < -32768);
      end
      3'b101: r = (sa < sb) ? 16'd1 : 16'd0;
      3'b110: r = a;
      default: r = 16'd0;
    endcase
    z = (r == 16'd0);
  endtask

  task automatic apply(input logic [15:0] a,
                       input logic [15:0] b,
                       input logic        bn,
                       input logic [2:0]  c,
                       input logic        rst);
    @(negedge clk);
    A = a;
    B = b;
    BNegate = bn;
    ALUCtrl = c;
    reset = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag,
                            input logic [15:0] r,
                            input logic        z,
                            input logic        ov,
                            input logic        co);
    chk({tag, "_rez"}, REZ, r);
    chk({tag, "_zero"}, {15'd0, Zero}, {15'd0, z});
    chk({tag, "_ovf"}, {15'd0, Overflow}, {15'd0, ov});
    chk({tag, "_co"}, {15'd0, CarryOut}, {15'd0, co});
  endtask

  task automatic dir(input string tag,
                     input logic [15:0] a,
                     input logic [15:0] b,
                     input logic        bn,
                     input logic [2:0]  c,
                     input logic [15:0] r,
                     input logic        z,
                     input logic        ov,
                     input logic        co);
    apply(a, b, bn, c, 1'b0);
    expect_out(tag, r, z, ov, co);
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] v;
    case ($urandom_range(0, 7))
      0: v = 16'h0000;
      1: v = 16'h0001;
      2: v = 16'h7FFF;
      3: v = 16'h8000;
      4: v = 16'hFFFF;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rbn;
    logic [2:0]  rc;
    logic        rrst;
    logic [15:0] er;
    logic        ez;
    logic        eov;
    logic        eco;

    reset = 1'b1;
    A = 16'h1234;
    B = 16'h5678;
    BNegate = 1'b0;
    ALUCtrl = 3'b100;

    apply(16'h1234, 16'h5678, 1'b0, 3'b100, 1'b1);
    apply(16'hFFFF, 16'h0001, 1'b0, 3'b100, 1'b1);
    expect_out("reset", 16'd0, 1'b1, 1'b0, 1'b0);

    dir("add_5_5", 16'd5, 16'd5, 1'b0, 3'b100, 16'd10, 1'b0, 1'b0, 1'b0);
    dir("add_6_3", 16'd6, 16'd3, 1'b0, 3'b100, 16'd9, 1'b0, 1'b0, 1'b0);
    dir("sub_5_5", 16'd5, 16'd5, 1'b1, 3'b100, 16'd0, 1'b1, 1'b0, 1'b1);
    dir("sub_6_3", 16'd6, 16'd3, 1'b1, 3'b100, 16'd3, 1'b0, 1'b0, 1'b1);
    dir("sub_3_6", 16'd3, 16'd6, 1'b1, 3'b100, 16'hFFFD, 1'b0, 1'b0, 1'b0);
    dir("xor_10_20", 16'd10, 16'd20, 1'b0, 3'b011, 16'd30, 1'b0, 1'b0, 1'b0);
    dir("xor_10_40", 16'd10, 16'd40, 1'b0, 3'b011, 16'd34, 1'b0, 1'b0, 1'b0);
    dir("and_10_10", 16'd10, 16'd10, 1'b0, 3'b000, 16'd10, 1'b0, 1'b0, 1'b0);
    dir("and_40_30", 16'd40, 16'd30, 1'b0, 3'b000, 16'd8, 1'b0, 1'b0, 1'b0);
    dir("or_5_5", 16'd5, 16'd5, 1'b0, 3'b010, 16'd5, 1'b0, 1'b0, 1'b0);
    dir("or_6_3", 16'd6, 16'd3, 1'b0, 3'b010, 16'd7, 1'b0, 1'b0, 1'b0);
    dir("ovf_pos", 16'h7FFF, 16'd1, 1'b0, 3'b100, 16'h8000, 1'b0, 1'b1, 1'b0);
    dir("ovf_neg", 16'h8000, 16'd1, 1'b1, 3'b100, 16'h7FFF, 1'b0, 1'b1, 1'b1);
    dir("wrap", 16'hFFFF, 16'd1, 1'b0, 3'b100, 16'd0, 1'b1, 1'b0, 1'b1);
    dir("slt_m1_1", 16'hFFFF, 16'd1, 1'b0, 3'b101, 16'd1, 1'b0, 1'b0, 1'b0);
    dir("slt_5_3", 16'd5, 16'd3, 1'b0, 3'b101, 16'd0, 1'b1, 1'b0, 1'b0);
    dir("slt_bn_5_3", 16'd5, 16'd3, 1'b1, 3'b101, 16'd0, 1'b1, 1'b0, 1'b0);
    dir("slt_ovf", 16'h8000, 16'h7FFF, 1'b0, 3'b101, 16'd1, 1'b0, 1'b0, 1'b0);
    dir("nor_0_0", 16'd0, 16'd0, 1'b0, 3'b001, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    dir("and_bn", 16'h00FF, 16'h0F0F, 1'b1, 3'b000, 16'h00F0, 1'b0, 1'b0, 1'b0);
    dir("pass", 16'h1234, 16'hFFFF, 1'b1, 3'b110, 16'h1234, 1'b0, 1'b0, 1'b0);
    dir("zero_op", 16'hFFFF, 16'hFFFF, 1'b0, 3'b111, 16'd0, 1'b1, 1'b0, 1'b0);

    dir("pre_rst", 16'd5, 16'd5, 1'b0, 3'b100, 16'd10, 1'b0, 1'b0, 1'b0);
    apply(16'hFFFF, 16'd1, 1'b0, 3'b100, 1'b1);
    expect_out("mid_rst", 16'd0, 1'b1, 1'b0, 1'b0);
    dir("post_rst", 16'd6, 16'd3, 1'b0, 3'b100, 16'd9, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      ra   = pick();
      rb   = pick();
      rbn  = 1'($urandom_range(0, 1));
      rc   = 3'($urandom_range(0, 7));
      rrst = ($urandom_range(0, 15) == 0);
      apply(ra, rb, rbn, rc, rrst);
      if (rrst) begin
        er = 16'd0;
        ez = 1'b1;
        eov = 1'b0;
        eco = 1'b0;
      end else begin
        model(ra, rb, rbn, rc, er, ez, eov, eco);
      end
      expect_out($sformatf("rnd%0d_op%0d", i, rc), er, ez, eov, eco);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
